// File: rtl/mmio_hub.sv
// MMIO hub between the dmem port and RAM: sensor/button inputs, writable output regs.
// Optional SENSOR_FILTER_EN builds a 4-sample moving-average filter per sensor channel.
module mmio_hub #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IN_CH      = 2,
  parameter int unsigned IN_W       = 9,
  parameter int unsigned BTN_N      = 4,
  parameter int unsigned OUT_CH     = 4,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wren,
  input  logic [ADDR_W-1:0]        address_dmem,
  input  logic [DATA_W-1:0]        data,
  output logic [DATA_W-1:0]        q_dmem,
  output logic                     ram_wEn,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_dataIn,
  input  logic [DATA_W-1:0]        ram_dataOut,
  input  logic [IN_CH*IN_W-1:0]    sensor_in,
  input  logic                     sensor_valid,
  input  logic [BTN_N-1:0]         btn_in,
  output logic [OUT_CH*DATA_W-1:0] out_regs
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic       mmio;
  logic [7:0] offset;
  logic       rd_en;
  logic       wr_en;

  assign mmio       = &address_dmem[ADDR_W-1:8];
  assign offset     = address_dmem[7:0];
  assign rd_en      = mmio & ~wren;
  assign wr_en      = mmio & wren;
  assign ram_wEn    = wren & ~mmio;
  assign ram_addr   = address_dmem;
  assign ram_dataIn = data;

  // Sensor channels
  logic [IN_W-1:0] sens_val [IN_CH];

`ifdef SENSOR_FILTER_EN
  localparam int unsigned SumW = IN_W + 2;
  logic [IN_W-1:0] hist_q   [IN_CH][4];
  logic [SumW-1:0] filt_sum [IN_CH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < IN_CH; c++) begin
        for (int k = 0; k < 4; k++) hist_q[c][k] <= '0;
      end
    end else if (sensor_valid) begin
      for (int c = 0; c < IN_CH; c++) begin
        hist_q[c][0] <= sensor_in[c*IN_W +: IN_W];
        for (int k = 1; k < 4; k++) hist_q[c][k] <= hist_q[c][k-1];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < IN_CH; c++) begin
      filt_sum[c] = SumW'(hist_q[c][0]) + SumW'(hist_q[c][1]) +
                    SumW'(hist_q[c][2]) + SumW'(hist_q[c][3]);
      sens_val[c] = filt_sum[c][SumW-1:2];
    end
  end
`else
  logic [IN_W-1:0] sens_q [IN_CH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < IN_CH; c++) sens_q[c] <= '0;
    end else if (sensor_valid) begin
      for (int c = 0; c < IN_CH; c++) sens_q[c] <= sensor_in[c*IN_W +: IN_W];
    end
  end

  always_comb begin
    for (int c = 0; c < IN_CH; c++) sens_val[c] = sens_q[c];
  end
`endif

  logic [15:0] smp_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)             smp_cnt_q <= '0;
    else if (sensor_valid) smp_cnt_q <= smp_cnt_q + 16'd1;
  end

  // Buttons: 2-FF sync, per-button debounce counter, sticky press latches
  logic [BTN_N-1:0] sync1_q, sync2_q, stable_q, latch_q, latch_d;
  logic [BTN_N-1:0] deb_done, press;
  logic [CntW-1:0]  deb_cnt_q [BTN_N];
  logic             rd_latch;

  assign rd_latch = rd_en && (offset == 8'h11);

  always_comb begin
    for (int b = 0; b < BTN_N; b++) begin
      deb_done[b] = (sync2_q[b] != stable_q[b]) && (deb_cnt_q[b] == CntMax);
    end
    press   = deb_done & sync2_q;
    // A press arriving in the read-clear cycle survives the clear
    latch_d = rd_latch ? press : (latch_q | press);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      latch_q  <= '0;
      for (int b = 0; b < BTN_N; b++) deb_cnt_q[b] <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      latch_q <= latch_d;
      for (int b = 0; b < BTN_N; b++) begin
        if (sync2_q[b] == stable_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_done[b]) begin
          stable_q[b]  <= sync2_q[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Output registers
  logic [DATA_W-1:0] out_q [OUT_CH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < OUT_CH; j++) out_q[j] <= '0;
    end else begin
      for (int j = 0; j < OUT_CH; j++) begin
        if (wr_en && (offset == 8'(32 + j))) out_q[j] <= data;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_CH; j++) out_regs[j*DATA_W +: DATA_W] = out_q[j];
  end

  // Read path
  logic [DATA_W-1:0] rd_data, rd_q;
  logic              flag_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < IN_CH; i++) begin
      if (offset == 8'(i)) rd_data = DATA_W'(sens_val[i]);
    end
    for (int j = 0; j < OUT_CH; j++) begin
      if (offset == 8'(32 + j)) rd_data = out_q[j];
    end
    if (offset == 8'h10) rd_data = DATA_W'(stable_q);
    if (offset == 8'h11) rd_data = DATA_W'(latch_q);
    if (offset == 8'h12) rd_data = DATA_W'(smp_cnt_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q   <= '0;
      flag_q <= 1'b0;
    end else begin
      rd_q   <= rd_data;
      flag_q <= mmio;
    end
  end

  assign q_dmem = flag_q ? rd_q : ram_dataOut;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub with a behavioural 1-cycle RAM and an expected-value queue.
module tb_mmio_hub;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IN_CH  = 2;
  localparam int unsigned IN_W   = 9;
  localparam int unsigned BTN_N  = 4;
  localparam int unsigned OUT_CH = 4;
  localparam int unsigned DEB    = 8;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     wren;
  logic [ADDR_W-1:0]        address_dmem;
  logic [DATA_W-1:0]        data;
  logic [DATA_W-1:0]        q_dmem;
  logic                     ram_wEn;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_dataIn;
  logic [DATA_W-1:0]        ram_dataOut;
  logic [IN_CH*IN_W-1:0]    sensor_in;
  logic                     sensor_valid;
  logic [BTN_N-1:0]         btn_in;
  logic [OUT_CH*DATA_W-1:0] out_regs;

  int n_chk = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;

  mmio_hub #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IN_CH(IN_CH), .IN_W(IN_W),
    .BTN_N(BTN_N), .OUT_CH(OUT_CH), .DEB_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem), .data(data),
    .q_dmem(q_dmem), .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .sensor_in(sensor_in), .sensor_valid(sensor_valid),
    .btn_in(btn_in), .out_regs(out_regs)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [4096];
  always @(posedge clock) begin
    if (reset) begin
      ram_dataOut <= '0;
    end else begin
      if (ram_wEn) mem[ram_addr] <= ram_dataIn;
      ram_dataOut <= mem[ram_addr];
    end
  end

  // One access cycle; returns #1 after the sampling edge with the bus idle.
  task automatic drive(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wren = we; address_dmem = a; data = d;
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0; data = '0;
  endtask

  task automatic sample(input logic [IN_W-1:0] c0, input logic [IN_W-1:0] c1);
    sensor_in = {c1, c0}; sensor_valid = 1'b1;
    @(posedge clock); #1;
    sensor_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (q_dmem !== 32'h0) begin
      n_fail++; $display("FAIL reset_q: got %h want 0", q_dmem);
    end
    n_chk++;
    if (out_regs !== '0) begin
      n_fail++; $display("FAIL reset_out: got %h want 0", out_regs);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] addrs [4];
      addrs = '{12'hF00, 12'hF10, 12'hF11, 12'hF12};
      exp_q.push_back(32'h0);
      drive(1'b0, addrs[i], '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL reset_rd %h: got %h want %h", addrs[i], q_dmem, exp_v);
      end
    end
  endtask

  task automatic test_passthrough();
    wren = 1'b1; address_dmem = 12'h005; data = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (ram_wEn !== 1'b1 || ram_addr !== 12'h005 || ram_dataIn !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pass_store: got wEn=%b addr=%h din=%h want 1/005/deadbeef",
               ram_wEn, ram_addr, ram_dataIn);
    end
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0; data = '0;
    exp_q.push_back(32'hDEADBEEF);
    drive(1'b0, 12'h005, '0);
    n_chk++; exp_v = exp_q.pop_front();
    if (q_dmem !== exp_v) begin
      n_fail++; $display("FAIL pass_load: got %h want %h", q_dmem, exp_v);
    end
  endtask

  task automatic test_outputs();
    logic [OUT_CH*DATA_W-1:0] exp_out;
    wren = 1'b1; address_dmem = 12'hF20; data = 32'h0000_0A0A;
    #1;
    n_chk++;
    if (ram_wEn !== 1'b0) begin
      n_fail++; $display("FAIL mmio_store_wen: got %b want 0", ram_wEn);
    end
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0;
    drive(1'b1, 12'hF21, 32'h0000_012C);
    n_chk++;
    if (out_regs[63:32] !== 32'h12C) begin
      n_fail++; $display("FAIL out_reg1: got %h want 12c", out_regs[63:32]);
    end
    drive(1'b1, 12'hF23, 32'hCAFE_0003);
    exp_out = {32'hCAFE_0003, 32'h0, 32'h12C, 32'h0A0A};
    n_chk++;
    if (out_regs !== exp_out) begin
      n_fail++; $display("FAIL out_all: got %h want %h", out_regs, exp_out);
    end
    exp_q.push_back(32'h12C);
    drive(1'b0, 12'hF21, '0);
    n_chk++; exp_v = exp_q.pop_front();
    if (q_dmem !== exp_v) begin
      n_fail++; $display("FAIL out_rd1: got %h want %h", q_dmem, exp_v);
    end
    exp_q.push_back(32'h0);
    drive(1'b0, 12'hF24, '0);
    n_chk++; exp_v = exp_q.pop_front();
    if (q_dmem !== exp_v) begin
      n_fail++; $display("FAIL out_rd_unmapped: got %h want %h", q_dmem, exp_v);
    end
  endtask

  task automatic test_sensor();
    logic [DATA_W-1:0] want0, want1;
`ifdef SENSOR_FILTER_EN
    want0 = 32'd250; want1 = 32'd25;
`else
    want0 = 32'd400; want1 = 32'd41;
`endif
    sample(9'd100, 9'd10);
    sample(9'd200, 9'd20);
    sample(9'd300, 9'd30);
    sample(9'd400, 9'd41);
    sensor_in = {9'd7, 9'd7};  // no strobe: must not be picked up
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(want0);
    exp_q.push_back(want1);
    exp_q.push_back(32'd4);
    for (int i = 0; i < 3; i++) begin
      logic [ADDR_W-1:0] addrs [3];
      addrs = '{12'hF00, 12'hF01, 12'hF12};
      drive(1'b0, addrs[i], '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL sensor_rd %h: got %0d want %0d", addrs[i], q_dmem, exp_v);
      end
    end
  endtask

  task automatic test_debounce();
    btn_in[2] = 1'b1;
    repeat (5) @(posedge clock);
    #1; btn_in[2] = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, (i == 0) ? 12'hF10 : 12'hF11, '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL glitch_rd%0d: got %h want %h", i, q_dmem, exp_v);
      end
    end
    btn_in[2] = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 0) ? 12'hF10 : 12'hF11, '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL press_rd%0d: got %h want %h", i, q_dmem, exp_v);
      end
    end
    btn_in[2] = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    exp_q.push_back(32'h0);
    drive(1'b0, 12'hF10, '0);
    n_chk++; exp_v = exp_q.pop_front();
    if (q_dmem !== exp_v) begin
      n_fail++; $display("FAIL release_rd: got %h want %h", q_dmem, exp_v);
    end
  endtask

  // Stable state flips on the 10th edge after the raw change (2 sync + 8 debounce).
  task automatic test_collision();
    btn_in[0] = 1'b1;
    repeat (9) @(posedge clock);
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 12'hF11, '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL collide_rd%0d: got %h want %h", i, q_dmem, exp_v);
      end
    end
    btn_in[0] = 1'b0;
    repeat (12) @(posedge clock);
    #1;
  endtask

  task automatic test_unmapped();
    logic [DATA_W-1:0] want0;
`ifdef SENSOR_FILTER_EN
    want0 = 32'd250;
`else
    want0 = 32'd400;
`endif
    drive(1'b1, 12'hF10, 32'h55);
    drive(1'b1, 12'hF7F, 32'h55);
    drive(1'b1, 12'hF12, 32'h55);
    drive(1'b1, 12'hF00, 32'h55);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'd4);
    exp_q.push_back(want0);
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] addrs [4];
      addrs = '{12'hF10, 12'hF7F, 12'hF12, 12'hF00};
      drive(1'b0, addrs[i], '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL ro_rd %h: got %h want %h", addrs[i], q_dmem, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [5];
    drive(1'b1, 12'h006, 32'h1234_5678);
    drive(1'b1, 12'hF22, 32'h0BAD_F00D);
    addrs = '{12'hF22, 12'h006, 12'hF21, 12'h005, 12'hF23};
    exp_q.push_back(32'h0BAD_F00D);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h12C);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hCAFE_0003);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, addrs[i], '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL b2b_rd %h: got %h want %h", addrs[i], q_dmem, exp_v);
      end
    end
  endtask

  task automatic test_reset_midop();
    reset = 1'b1; wren = 1'b1; address_dmem = 12'hF22; data = 32'h7777_7777;
    @(posedge clock); #1;
    reset = 1'b0; wren = 1'b0; address_dmem = '0; data = '0;
    n_chk++;
    if (out_regs !== '0) begin
      n_fail++; $display("FAIL midreset_out: got %h want 0", out_regs);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, (i == 0) ? 12'hF12 : 12'hF00, '0);
      n_chk++; exp_v = exp_q.pop_front();
      if (q_dmem !== exp_v) begin
        n_fail++; $display("FAIL midreset_rd%0d: got %h want %h", i, q_dmem, exp_v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset = 1'b1; wren = 1'b0; address_dmem = '0; data = '0;
    sensor_in = '0; sensor_valid = 1'b0; btn_in = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_passthrough();
    test_outputs();
    test_sensor();
    test_debounce();
    test_collision();
    test_unmapped();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_hub.md
# mmio_hub

Memory-mapped peripheral hub between the processor data-memory port and RAM. It replaces hard-wired register-file taps with a parametrised MMIO window. Inputs are IN_CH sensor channels (accelerometer axes), optionally filtered, plus BTN_N debounced buttons with sticky press latches. Outputs are OUT_CH processor-writable registers driven to the VGA controller (player/target positions). All other addresses pass through to RAM unchanged.

## Interface
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- IN_CH, 2, sensor channels (1-8)
- IN_W, 9, raw sensor width (≤16, unsigned)
- BTN_N, 4, buttons (1-16)
- OUT_CH, 4, output registers (1-16)
- DEB_CYCLES, 500000, debounce stability count (≥2)
- clock in 1 single clock, all logic on rising edge
- reset in 1 synchronous, active-high
- wren in 1 processor store enable
- address_dmem in ADDR_W processor word address
- data in DATA_W processor store data
- q_dmem out DATA_W load data, registered
- ram_wEn out 1 RAM write enable
- ram_addr out ADDR_W RAM address (= address_dmem)
- ram_dataIn out DATA_W RAM write data (= data)
- ram_dataOut in DATA_W RAM read data (1-cycle registered RAM)
- sensor_in in IN_CH*IN_W packed raw samples, ch0 in LSBs
- sensor_valid in 1 one-cycle strobe: all channels carry a new sample
- btn_in in BTN_N raw asynchronous buttons
- out_regs out OUT_CH*DATA_W packed output registers, reg0 in LSBs

## Operation
- Decode: mmio = (address_dmem[ADDR_W-1:8] all ones), i.e. 0xF00-0xFFF at ADDR_W=12. ram_wEn = wren & ~mmio; MMIO stores never reach RAM.
- Register map (offset = address_dmem[7:0]):
  - 0x00+i, i<IN_CH: filtered sensor i, zero-extended, RO.
  - 0x10: debounced button state, bit b = button b, RO.
  - 0x11: press latches, read-to-clear.
  - 0x12: sample counter, 16-bit, counts sensor_valid strobes, wraps 0xFFFF→0, zero-extended, RO.
  - 0x20+j, j<OUT_CH: output register j, R/W.
  - Any other offset reads 0; writes are ignored. Writes to RO offsets are ignored.
- Sensor path: on sensor_valid, each channel updates its value (see Configuration). Channels update together; no per-channel strobe.
- Buttons: each input passes a 2-FF synchroniser. Per button, a counter runs while the synchronised input differs from the stable state; the counter clears whenever they match. On reaching DEB_CYCLES-1 the stable state takes the input and the counter clears.
- Press latch bit b sets on a stable 0→1 transition of button b. A load from 0x11 returns the latches, then clears the bits returned. If a press sets a bit in the same cycle it is read-cleared, the bit stays set.
- Output registers: a store to 0x20+j updates reg j on that edge. out_regs is driven directly from the registers.
- Load mux: a registered flag holds the previous cycle's mmio decode. q_dmem = flag ? registered MMIO read data : ram_dataOut.
- Reset values:
  - q_dmem 0, out_regs 0, filtered values 0, filter history 0.
  - Button stable state 0, latches 0, debounce counters 0, synchronisers 0.
  - Sample counter 0, mux flag 0 (RAM path).
- Reset mid-operation: all state returns to reset values on that edge. A store in the same cycle as reset is discarded.

## Timing
- Load latency is 1 cycle for both RAM and MMIO. Address at edge N gives valid q_dmem after edge N+1.
- Store to an out register at edge N: out_regs changes after edge N. A load of the same register issued at edge N+1 returns the new value.
- Store and load of the same MMIO register in one cycle are not possible (single port). Back-to-back accesses are supported every cycle.
- sensor_valid at edge N: register updated at N. A load issued at N+1 returns the new value.
- Button latency: 2 synchroniser cycles + DEB_CYCLES cycles from raw change to stable-state change.
- Glitches shorter than DEB_CYCLES are never reflected.

## Configuration
- SENSOR_FILTER_EN defined:
  - Each channel keeps a 4-deep history of samples.
  - Output = (sum of last 4 samples) >> 2, with sum width IN_W+2, truncated toward zero.
  - History shifts only on sensor_valid.
- Undefined: each channel register holds the latest raw sample; no history logic is built.

## Test plan
- Passthrough: store 0xDEADBEEF to 0x005, load 0x005 → ram_wEn=1 on the store; q_dmem=0xDEADBEEF one cycle after the load address. A store to 0xF20 gives ram_wEn=0.
- Outputs: store 0x0000012C to 0xF21 → out_regs[63:32]=0x12C the next cycle; load 0xF21 returns 0x12C; reset returns all out_regs to 0.
- Sensor, SENSOR_FILTER_EN defined: ch0 samples 100, 200, 300, 400, each with sensor_valid → load 0xF00 returns 250; 0xF12 returns 4.
- Sensor, SENSOR_FILTER_EN undefined: same stimulus → load 0xF00 returns 400.
- Debounce (DEB_CYCLES=8): btn_in[2] high for 5 cycles then low → 0xF10=0, 0xF11=0. Held high for 12 cycles → 0xF10 bit2=1, 0xF11 returns 0x4, a second 0xF11 read returns 0.
- Collision: new press on button 0 in the same cycle 0xF11 is read-cleared → the returned value excludes bit0; the next read returns bit0=1.
- Unmapped and RO: store 0x55 to 0xF10 or 0xF7F → 0xF10 is unchanged and 0xF7F reads 0.
